// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder.
// Covers per-stage chunk sizing and parameter legality.
package adder_pkg;

    // Number of sum bits produced by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // The width must split into equal, non-empty chunks, one per stage.
    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               (width % stages == 0);
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_ripple_chunk.sv
// Combinational CHUNK-bit ripple-carry adder.
// This block holds one pipeline stage's slice of the add. It has no state.
module ripple_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i. c[CHUNK] is the carry out of the chunk.
    logic [CHUNK:0] c;

    // Ripple the carry from the LSB to the MSB of the chunk.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // leaves one unassigned and no latch is inferred.
        c    = '0;
        sum  = '0;
        c[0] = cin;
        // NOTE: use blocking assignments in combinational logic. Each
        // iteration must see the carry that the previous iteration just
        // computed.
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder with a valid/ready handshake on both sides.
// Each stage adds one CHUNK-bit slice and passes the carry forward.
// An empty stage always accepts a beat, so bubbles collapse under back-pressure.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_ripple_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    // Inter-stage links. Index 0 is the input port side. Index s is the
    // register output of stage s.
    // link_a/link_b carry the operand bits that are not yet added, shifted
    // down so that the next chunk always sits at bit 0.
    logic [WIDTH-1:0] link_a  [0:STAGES-1];
    logic [WIDTH-1:0] link_b  [0:STAGES-1];
    logic [WIDTH-1:0] link_s  [0:STAGES];
    logic             link_c  [0:STAGES];
    logic             link_v  [0:STAGES];
    logic             chunk_m [1:STAGES];
    logic [STAGES:1]  adv;
    logic             msb_c_q;

    assign link_a[0] = a;
    assign link_b[0] = b;
    assign link_s[0] = '0;
    assign link_c[0] = cin;
    assign link_v[0] = in_valid;

    // A stage may load when the stage after it moves, or when it holds no beat.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready || !link_v[STAGES];
        for (int k = STAGES - 1; k >= 1; k--) begin
            adv[k] = adv[k + 1] || !link_v[k];
        end
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int LO = (s - 1) * CHUNK;

        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_cout;
        logic [WIDTH-1:0] sum_next;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        assign op_a = CHUNK'(link_a[s-1]);
        assign op_b = CHUNK'(link_b[s-1]);

        ripple_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (op_a),
            .b     (op_b),
            .cin   (link_c[s-1]),
            .sum   (chunk_sum),
            .cout  (chunk_cout),
            .c_msb (chunk_m[s])
        );

        // Add this stage's chunk to the partial sum it received.
        always_comb begin
            sum_next                = link_s[s-1];
            sum_next[LO +: CHUNK]   = chunk_sum;
        end

        // Stage register: load on advance, otherwise hold every field.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: clear the data registers as well as the valid bit.
                // After reset, sum and carry must read as 0, not as stale or X values.
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv[s]) begin
                v_q <= link_v[s-1];
                c_q <= chunk_cout;
                s_q <= sum_next;
            end
        end

        assign link_v[s] = v_q;
        assign link_c[s] = c_q;
        assign link_s[s] = s_q;

        if (s < STAGES) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Pass the unconsumed operand bits down, with the next chunk at bit 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[s]) begin
                    a_q <= link_a[s-1] >> CHUNK;
                    b_q <= link_b[s-1] >> CHUNK;
                end
            end

            assign link_a[s] = a_q;
            assign link_b[s] = b_q;
        end
    end

    // Last stage: keep the carry into the word MSB so overflow can be derived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_c_q <= 1'b0;
        end else if (adv[STAGES]) begin
            msb_c_q <= chunk_m[STAGES];
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = link_v[STAGES];
    assign sum       = link_s[STAGES];
    assign carry     = link_c[STAGES];
    assign overflow  = msb_c_q ^ link_c[STAGES];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder.
// A queue of expected results, computed with plain arithmetic, is checked
// against the main 16/4 instance on every cycle. The 8/1 and 32/8 instances
// are checked with directed beats.
module tb_pipelined_ripple_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance, WIDTH=16 STAGES=4.
    logic         in_valid, in_ready, cin, out_valid, out_ready, carry, overflow;
    logic [W-1:0] a, b, sum;

    // Sweep instance, WIDTH=8 STAGES=1.
    logic         n8_in_valid, n8_in_ready, n8_cin, n8_out_valid, n8_out_ready, n8_carry, n8_overflow;
    logic [7:0]   n8_a, n8_b, n8_sum;

    // Sweep instance, WIDTH=32 STAGES=8.
    logic         n32_in_valid, n32_in_ready, n32_cin, n32_out_valid, n32_out_ready, n32_carry, n32_overflow;
    logic [31:0]  n32_a, n32_b, n32_sum;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
        .a(n8_a), .b(n8_b), .cin(n8_cin), .out_valid(n8_out_valid), .out_ready(n8_out_ready),
        .sum(n8_sum), .carry(n8_carry), .overflow(n8_overflow)
    );

    pipelined_ripple_adder #(.WIDTH(32), .STAGES(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(n32_in_valid), .in_ready(n32_in_ready),
        .a(n32_a), .b(n32_b), .cin(n32_cin), .out_valid(n32_out_valid), .out_ready(n32_out_ready),
        .sum(n32_sum), .carry(n32_carry), .overflow(n32_overflow)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } result_t;

    result_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: compute the full-width sum, then read off the carry and signed overflow.
    function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        result_t      r;
        logic [W:0]   full;
        full    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        r.ovf   = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    // Compare process: runs mid-cycle and predicts the transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("mon_in_ready", 64'(in_ready), 64'((exp_q.size() < S) || out_ready));
            if (exp_q.size() == 0) begin
                check("mon_idle_valid", 64'(out_valid), 64'(0));
            end else if (out_valid) begin
                check("mon_sum",   64'(sum),      64'(exp_q[0].sum));
                check("mon_carry", 64'(carry),    64'(exp_q[0].carry));
                check("mon_ovf",   64'(overflow), 64'(exp_q[0].ovf));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    // Present one beat on the main instance to an empty pipe. Count edges until out_valid.
    task automatic single_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, output int lat);
        @(posedge clk); #1;
        in_valid  = 1'b1; a = x; b = y; cin = ci; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, acc, k, first, lastv, nvalid, drops, base, sent, cyc, guard;
        logic fire, pending;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        n8_in_valid = 1'b0; n8_a = '0; n8_b = '0; n8_cin = 1'b0; n8_out_ready = 1'b1;
        n32_in_valid = 1'b0; n32_a = '0; n32_b = '0; n32_cin = 1'b0; n32_out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(16'h0000));
        check("rst_carry",     64'(carry),     64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_n8_valid",  64'(n8_out_valid),  64'(0));
        check("rst_n32_valid", 64'(n32_out_valid), 64'(0));

        // Single beats: unsigned wrap-around, then signed overflow.
        single_beat(16'hFFFF, 16'h0001, 1'b0, lat);
        check("t2a_latency", 64'(lat),      64'(4));
        check("t2a_sum",     64'(sum),      64'(16'h0000));
        check("t2a_carry",   64'(carry),    64'(1));
        check("t2a_ovf",     64'(overflow), 64'(0));
        single_beat(16'h7FFF, 16'h0001, 1'b0, lat);
        check("t2b_latency", 64'(lat),      64'(4));
        check("t2b_sum",     64'(sum),      64'(16'h8000));
        check("t2b_carry",   64'(carry),    64'(0));
        check("t2b_ovf",     64'(overflow), 64'(1));

        // Streaming: 8 back-to-back beats.
        @(posedge clk); #1;
        first = -1; lastv = -1; nvalid = 0; drops = 0;
        for (int i = 0; i < 8 + S + 2; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; a = 16'(i * 16'h1111); b = 16'h0F0F; cin = i[0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            if (i < 8 && !in_ready) drops++;
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = i;
                lastv = i;
            end
            @(posedge clk); #1;
        end
        check("t3_ready_drops", 64'(drops),             64'(0));
        check("t3_results",     64'(nvalid),            64'(8));
        check("t3_contiguous",  64'(lastv - first + 1), 64'(8));
        check("t3_first_cycle", 64'(first),             64'(S));

        // Back-pressure: fill the pipe, hold the output, then pop and push in the same cycle.
        base = pops; acc = 0; k = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = 16'(16'h1000 + k); b = 16'(k * 3); cin = k[0];
            @(negedge clk);
            fire = in_ready;
            if (fire) acc++;
            @(posedge clk); #1;
            if (fire) k++;
        end
        a = 16'(16'h1000 + k); b = 16'(k * 3); cin = k[0];
        check("t4_accepted", 64'(acc), 64'(4));
        @(negedge clk);
        check("t4_full_in_ready", 64'(in_ready),  64'(0));
        check("t4_head_valid",    64'(out_valid), 64'(1));
        check("t4_head_sum",      64'(sum),       64'(16'h1000));
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_hold_sum",      64'(sum),       64'(16'h1000));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_passthru_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t4_still_full",  64'(in_ready),  64'(0));
        check("t4_next_valid",  64'(out_valid), 64'(1));
        check("t4_next_sum",    64'(sum),       64'(16'h1005));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (S + 2) @(posedge clk);
        #1;
        check("t4_drained", 64'(exp_q.size()), 64'(0));
        check("t4_popped",  64'(pops - base),  64'(5));

        // Bubbles: input valid on alternate cycles, output ready 50% of the time.
        base = pops; sent = 0; cyc = 0; guard = 0; pending = 1'b0;
        while (sent < 30 && guard < 2000) begin
            if (!pending) begin
                if (cyc % 2 == 0) begin
                    in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
                    pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                pending = 1'b0;
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t5_sent",    64'(sent),          64'(30));
        check("t5_popped",  64'(pops - base),   64'(30));
        check("t5_drained", 64'(exp_q.size()),  64'(0));

        // Asynchronous reset with a full pipe: outputs clear before the next edge.
        out_ready = 1'b0;
        for (int i = 0; i < S + 1; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst_pre_valid", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_sum",       64'(sum),       64'(16'h0000));
        check("arst_carry",     64'(carry),     64'(0));
        check("arst_overflow",  64'(overflow),  64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        single_beat(16'h1234, 16'h4321, 1'b1, lat);
        check("post_rst_latency", 64'(lat), 64'(4));
        check("post_rst_sum",     64'(sum), 64'(16'h5556));

        // Config sweep, WIDTH=8 STAGES=1.
        @(posedge clk); #1;
        n8_in_valid = 1'b1; n8_a = 8'hFF; n8_b = 8'h00; n8_cin = 1'b1;
        @(posedge clk); #1;
        n8_in_valid = 1'b0;
        lat = 1;
        while (!n8_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n8_latency", 64'(lat),         64'(1));
        check("n8_sum",     64'(n8_sum),      64'(8'h00));
        check("n8_carry",   64'(n8_carry),    64'(1));
        check("n8_ovf",     64'(n8_overflow), 64'(0));

        // Config sweep, WIDTH=32 STAGES=8.
        @(posedge clk); #1;
        n32_in_valid = 1'b1; n32_a = 32'hFFFF_FFFF; n32_b = 32'h0; n32_cin = 1'b1;
        @(posedge clk); #1;
        n32_in_valid = 1'b0;
        lat = 1;
        while (!n32_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n32_latency", 64'(lat),          64'(8));
        check("n32_sum",     64'(n32_sum),      64'(32'h0));
        check("n32_carry",   64'(n32_carry),    64'(1));
        check("n32_ovf",     64'(n32_overflow), 64'(0));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
